// File: rtl/ad9361_spi_rd_pkg.sv
`timescale 1ns/1ps
// ad9361_spi_rd_pkg
//   Shared definitions for the AD9361 SPI register-read master:
//   FSM state encodings, instruction-word field positions, frame length,
//   and a helper that builds the 16-bit instruction word.
package ad9361_spi_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int FRAME_LEN    = 24;  // 16-bit instruction + 8 data bits
  localparam int INSTR_LEN    = 16;
  localparam int RX_FIRST_BIT = 16;  // first frame bit that carries slave data
  localparam int INSTR_RW_BIT = 15;  // 1 = write, 0 = read
  localparam int INSTR_NB_MSB = 14;  // byte-count field
  localparam int INSTR_NB_LSB = 13;
  localparam logic [1:0] NB_ONE_BYTE = 2'b00;

  // Instruction word: {rw, byte count, 3'b000, addr[9:0]}
  function automatic logic [INSTR_LEN-1:0] spi_instr(input logic rw, input logic [9:0] addr);
    logic [INSTR_LEN-1:0] w;
    w = '0;
    w[INSTR_RW_BIT] = rw;
    w[INSTR_NB_MSB:INSTR_NB_LSB] = NB_ONE_BYTE;
    w[9:0] = addr;
    return w;
  endfunction

endpackage

// File: rtl/ad9361_spi_tick.sv
`timescale 1ns/1ps
// ad9361_spi_tick
//   SCLK half-period divider. While en is high it counts CLK_DIV cycles per
//   half period and alternately emits a one-cycle sclk_fall then sclk_rise
//   strobe. The count is held cleared while en is low, so every enable
//   rising edge starts a fresh half period (SCLK is already high on entry).
// Ports
//   clk_100m  in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   divider enable (high during the shift phase)
//   sclk_rise out  1-cycle strobe: end of the low half period
//   sclk_fall out  1-cycle strobe: end of the high half period
module ad9361_spi_tick #(
  parameter int CLK_DIV = 10
) (
  input  logic clk_100m,
  input  logic rst_n,
  input  logic en,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [7:0] div_reg;
  logic       phase_reg;  // 0 = SCLK high half, 1 = SCLK low half
  logic       half_done;

  assign half_done = (div_reg == 8'(CLK_DIV - 1));
  assign sclk_fall = en & half_done & ~phase_reg;
  assign sclk_rise = en & half_done & phase_reg;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      div_reg   <= 8'd0;
      phase_reg <= 1'b0;
    end else if (!en) begin
      div_reg   <= 8'd0;
      phase_reg <= 1'b0;
    end else if (half_done) begin
      div_reg   <= 8'd0;
      phase_reg <= ~phase_reg;
    end else begin
      div_reg   <= div_reg + 8'd1;
    end
  end

endmodule

// File: rtl/ad9361_spi_rd.sv
`timescale 1ns/1ps
// ad9361_spi_rd
//   SPI master (mode 1, CPOL=0 CPHA=1) for single-byte AD9361 register reads.
//   Each level change on rd_flag while idle launches one 24-bit frame
//   {instruction(addr), 8 data bits}; the byte clocked in on spi_miso is
//   presented on rd_data_o with a one-cycle rd_valid_o pulse. busy stays high
//   from the cycle after acceptance until the FSM returns to IDLE; requests
//   arriving while busy are dropped.
//   Optional macro AD9361_SPI_WR_EN adds wr_req_i/wr_data_i for single-byte
//   write frames (same timing, no read-data update; a read request in the
//   same cycle takes priority).
// Ports
//   clk_100m   in   system clock
//   rst_n      in   asynchronous active-low reset
//   rd_flag    in   read request toggle
//   addr_i     in   register address, sampled on the request cycle
//   wr_req_i   in   (AD9361_SPI_WR_EN) write request pulse
//   wr_data_i  in   (AD9361_SPI_WR_EN) write byte
//   busy       out  transfer in progress
//   rd_data_o  out  last byte read
//   rd_valid_o out  1-cycle pulse when rd_data_o updates
//   spi_cs_n   out  chip select, active low
//   spi_clk    out  SCLK, idles low
//   spi_mosi   out  serial data to AD9361
//   spi_miso   in   serial data from AD9361
module ad9361_spi_rd
  import ad9361_spi_rd_pkg::*;
#(
  parameter int CLK_DIV  = 10,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 10
) (
  input  logic       clk_100m,
  input  logic       rst_n,
  input  logic       rd_flag,
  input  logic [9:0] addr_i,
`ifdef AD9361_SPI_WR_EN
  input  logic       wr_req_i,
  input  logic [7:0] wr_data_i,
`endif
  output logic       busy,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       spi_cs_n,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  state_t                 state_reg;
  logic                   rd_flag_d;
  logic [7:0]             cnt_reg;      // SETUP/HOLD/GAP cycle counter
  logic [4:0]             bit_cnt_reg;  // frame bit index 0..23
  logic [FRAME_LEN-1:0]   tx_reg;       // MSB is the next bit to drive
  logic [7:0]             rx_reg;
  logic                   wr_mode_reg;  // current frame is a write
  logic                   req;
  logic                   start_wr;
  logic [FRAME_LEN-1:0]   rd_frame;
  logic [FRAME_LEN-1:0]   wr_frame;
  logic                   sclk_rise;
  logic                   sclk_fall;

  assign req      = rd_flag ^ rd_flag_d;
  assign rd_frame = {spi_instr(1'b0, addr_i), 8'h00};

`ifdef AD9361_SPI_WR_EN
  assign start_wr = wr_req_i;
  assign wr_frame = {spi_instr(1'b1, addr_i), wr_data_i};
`else
  assign start_wr = 1'b0;
  assign wr_frame = '0;
`endif

  ad9361_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_100m  (clk_100m),
    .rst_n     (rst_n),
    .en        (state_reg == ST_SHIFT),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      rd_flag_d   <= 1'b0;
      cnt_reg     <= 8'd0;
      bit_cnt_reg <= 5'd0;
      tx_reg      <= '0;
      rx_reg      <= 8'h00;
      wr_mode_reg <= 1'b0;
      busy        <= 1'b0;
      rd_data_o   <= 8'h00;
      rd_valid_o  <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_clk     <= 1'b0;
      spi_mosi    <= 1'b0;
    end else begin
      // The edge detector tracks rd_flag in every state, so toggles seen
      // while busy are consumed and never replayed later.
      rd_flag_d  <= rd_flag;
      rd_valid_o <= 1'b0;

      unique case (state_reg)
        ST_IDLE: begin
          if (req || start_wr) begin
            state_reg   <= ST_SETUP;
            cnt_reg     <= 8'd0;
            busy        <= 1'b1;
            spi_cs_n    <= 1'b0;
            tx_reg      <= req ? rd_frame : wr_frame;
            wr_mode_reg <= ~req;  // read wins a same-cycle collision
          end
        end

        ST_SETUP: begin
          if (cnt_reg == 8'(CS_SETUP - 1)) begin
            // First rising SCLK edge launches bit 23.
            state_reg   <= ST_SHIFT;
            bit_cnt_reg <= 5'd0;
            spi_clk     <= 1'b1;
            spi_mosi    <= tx_reg[FRAME_LEN-1];
            tx_reg      <= {tx_reg[FRAME_LEN-2:0], 1'b0};
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        ST_SHIFT: begin
          if (sclk_fall) begin
            spi_clk <= 1'b0;
            if (bit_cnt_reg >= 5'(RX_FIRST_BIT))
              rx_reg <= {rx_reg[6:0], spi_miso};
          end
          if (sclk_rise) begin
            if (bit_cnt_reg == 5'(FRAME_LEN - 1)) begin
              // End of the last low half period: frame complete.
              state_reg <= ST_HOLD;
              cnt_reg   <= 8'd0;
              spi_mosi  <= 1'b0;
              if (!wr_mode_reg) begin
                rd_data_o  <= rx_reg;
                rd_valid_o <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
              spi_clk     <= 1'b1;
              spi_mosi    <= tx_reg[FRAME_LEN-1];
              tx_reg      <= {tx_reg[FRAME_LEN-2:0], 1'b0};
            end
          end
        end

        ST_HOLD: begin
          if (cnt_reg == 8'(CS_HOLD - 1)) begin
            state_reg <= ST_GAP;
            cnt_reg   <= 8'd0;
            spi_cs_n  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        ST_GAP: begin
          if (cnt_reg == 8'(CS_GAP - 1)) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
            busy      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          spi_cs_n  <= 1'b1;
          spi_clk   <= 1'b0;
          spi_mosi  <= 1'b0;
        end
      endcase
    end
  end

endmodule
